matmul_result_drain: RTL

- Consumer at the far end of the systolic matrix-multiply result interface.
- Watches `complete` and snapshots the N×N byte result matrix `matrix_c`.
- Streams the snapshot out one element per handshake on a valid/ready byte stream, then waits for the multiplier to be reset before rearming.
- Frees the multiplier for the next job while the result drains.

---
 rtl/matmul_result_drain.sv | 98 +++++++++
 1 files changed

// File: rtl/matmul_result_drain.sv
// Result-drain consumer for the systolic matrix multiplier: snapshots matrix_c on
// complete, streams it one byte per valid/ready handshake, then waits for complete to fall.
module matmul_result_drain #(
  parameter int N         = 4,
  parameter bit COL_MAJOR = 1'b0,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [0:N-1][0:N-1][0:7]    matrix_c,
  input  logic                        complete,
  input  logic                        abort,
  output logic [7:0]                  out_data,
  output logic [IW-1:0]               out_row,
  output logic [IW-1:0]               out_col,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        done,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(N * N - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [0:N-1][0:N-1][0:7]   snap_q, snap_d;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    unique case (state_q)
      IDLE:    if (complete) state_d = CAPTURE;
      CAPTURE: begin
        snap_d  = matrix_c;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) state_d = DONE;
          else                   cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE:    if (!complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort outranks a simultaneous transfer; the snapshot is deliberately kept.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  int unsigned idx, major, minor, row_i, col_i;

  always_comb begin
    idx   = int'(cnt_q);
    major = idx / N;
    minor = idx % N;
    row_i = COL_MAJOR ? minor : major;
    col_i = COL_MAJOR ? major : minor;

    out_valid = (state_q == STREAM);
    out_last  = out_valid && (cnt_q == LAST_IDX);
    done      = (state_q == DONE);
    busy      = (state_q == CAPTURE) || (state_q == STREAM);
    out_row   = out_valid ? IW'(row_i) : '0;
    out_col   = out_valid ? IW'(col_i) : '0;

    // Constant-index mux keeps the select width-clean for every N.
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (out_valid && row_i == i && col_i == j) out_data = snap_q[i][j];
      end
    end
  end

endmodule
